ddr_app_master: RTL
===================

DDR_APP_MASTER -- requirements
Module: ddr_app_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, app address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, app data width (2*nCK_PER_CLK*64).
REQ-003 SHALL have parameter LEN_WIDTH, default 16, burst-count width.
REQ-004 SHALL have parameter ADDR_STEP, default 8, address increment per burst.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 32, read bursts in flight limit.
REQ-006 Clock and reset SHALL be: one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-007 Ports (name direction width meaning):
 clk  in  1  UI clock
 rst  in  1  async active-high reset
 init_calib_complete  in  1  DDR calibrated
 req_valid  in  1  request strobe
 req_ready  out  1  request accept
 req_wr  in  1  1=write, 0=read
 req_addr  in  ADDR_WIDTH  start address
 req_len  in  LEN_WIDTH  burst count
 wr_data  in  DATA_WIDTH  write beat
 wr_valid  in  1  write beat valid
 wr_ready  out  1  write beat accept
 rd_data  out  DATA_WIDTH  read beat
 rd_valid  out  1  read beat valid (no backpressure)
 busy  out  1  transfer active
 done  out  1  one-cycle completion pulse
 app_addr  out  ADDR_WIDTH;  app_cmd  out  3;  app_en  out  1;  app_rdy  in  1
 app_wdf_data  out  DATA_WIDTH;  app_wdf_end  out  1;  app_wdf_mask  out  DATA_WIDTH/8;  app_wdf_wren  out  1;  app_wdf_rdy  in  1
 app_rd_data  in  DATA_WIDTH;  app_rd_data_end  in  1;  app_rd_data_valid  in  1

Function
REQ-008 FSM states IDLE, WRITE, READ, DRAIN, DONE; IDLE->WRITE/READ on req_valid&req_ready per req_wr; WRITE->DONE when data_cnt==cmd_cnt==len; READ->DRAIN when cmd_cnt==len; DRAIN->DONE when rd_cnt==len; DONE->IDLE after one cycle.
REQ-009 req_ready SHALL equal (state==IDLE)&init_calib_complete; req fields latched on handshake.
REQ-010 req_len==0 SHALL go IDLE->DONE directly, issuing no app commands.
REQ-011 Command handshake SHALL be app_en&app_rdy; app_en, app_addr, app_cmd held stable until accepted.
REQ-012 app_cmd SHALL be 3'b000 for write, 3'b001 for read.
REQ-013 app_addr SHALL start at req_addr and add ADDR_STEP per accepted command, wrapping modulo 2^ADDR_WIDTH.
REQ-014 WRITE: app_wdf_data=wr_data, app_wdf_wren=wr_valid&(data_cnt<len), wr_ready=app_wdf_rdy&(data_cnt<len), app_wdf_end=app_wdf_wren, app_wdf_mask=all zeros.
REQ-015 WRITE: app_en SHALL assert only when cmd_cnt<data_cnt (data always precedes its command).
REQ-016 READ: app_en SHALL assert when cmd_cnt<len and (cmd_cnt-rd_cnt)<MAX_OUTSTANDING.
REQ-017 rd_data/rd_valid SHALL be app_rd_data/app_rd_data_valid registered, latency exactly 1 cycle; rd_cnt increments per app_rd_data_valid.
REQ-018 Simultaneous command accept and read return in one cycle SHALL update both counters correctly.
REQ-019 busy SHALL be high in WRITE, READ, DRAIN, DONE; done high only in DONE.
REQ-020 app_rd_data_valid outside READ/DRAIN SHALL be ignored (no rd_valid, no count).

Reset
REQ-021 rst SHALL asynchronously force IDLE, clear counters, and drive req_ready, wr_ready, rd_valid, busy, done, app_en, app_wdf_wren, app_wdf_end to 0, app_addr/app_cmd to 0.
REQ-022 rst mid-transfer SHALL abandon the transfer; no done pulse is produced.

Structure
REQ-023 Package ddr_app_pkg SHALL hold CMD_WRITE, CMD_READ constants and the state enum.
REQ-024 Single flat module; no sub-module is warranted.

Verification
REQ-025 calib=0, req_valid=1 -> req_ready=0, no app_en; calib=1 -> accepted next cycle.
REQ-026 Write addr=0x100, len=4, app_rdy/app_wdf_rdy=1 -> 4 wdf beats, commands 000 at 0x100,0x108,0x110,0x118, one done pulse.
REQ-027 Read addr=0x3FFFFFF8, len=3 -> app_addr 0x3FFFFFF8, 0x0, 0x8; 3 rd_valid beats each 1 cycle after app_rd_data_valid; done after third.
REQ-028 Read len=40, MAX_OUTSTANDING=32, no returns -> exactly 32 commands then app_en=0 until a return.
REQ-029 app_rdy toggling 1-of-3 during write len=2 -> app_addr/app_cmd stable while app_en&~app_rdy; no command before its data beat.
REQ-030 rst asserted mid-read len=8 after 3 commands -> outputs zero immediately, FSM IDLE, no done.

Source files
------------

// File: rtl/ddr_app_pkg.sv
// Shared definitions for the DDR application-interface master: MIG command
// encodings and the transfer FSM state type.
package ddr_app_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/ddr_app_master.sv
// DDR application-interface master. Turns one request (address, burst count,
// direction) into a stream of MIG app commands. Writes push data ahead of the
// matching command. Reads cap the number of bursts in flight and forward the
// returned beats one cycle later.
module ddr_app_master
  import ddr_app_pkg::*;
#(
  parameter int ADDR_WIDTH      = 30,
  parameter int DATA_WIDTH      = 512,
  parameter int LEN_WIDTH       = 16,
  parameter int ADDR_STEP       = 8,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_calib_complete,
  // request side
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  // user write/read data
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done,
  // MIG app command port
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  // MIG app write-data port
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic                    app_wdf_end,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                    app_wdf_wren,
  input  logic                    app_wdf_rdy,
  // MIG app read-data port
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  input  logic                    app_rd_data_end,
  input  logic                    app_rd_data_valid
);

  state_e                  state_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              cmd_q;
  logic [LEN_WIDTH-1:0]    cmd_cnt_q;
  logic [LEN_WIDTH-1:0]    data_cnt_q;
  logic [LEN_WIDTH-1:0]    rd_cnt_q;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;

  logic                    in_write;
  logic                    in_read_phase;
  logic                    data_left;
  logic [LEN_WIDTH-1:0]    outstanding;
  logic                    req_fire;
  logic                    cmd_fire;
  logic                    beat_fire;
  logic                    ret_fire;

  // Every read burst is a single beat, so the end marker carries no extra
  // information here.
  logic                    unused_rd_end;
  assign unused_rd_end = app_rd_data_end;

  assign in_write      = (state_q == WRITE);
  assign in_read_phase = (state_q == READ) || (state_q == DRAIN);
  assign data_left     = (data_cnt_q < len_q);
  assign outstanding   = cmd_cnt_q - rd_cnt_q;

  // Reset gates req_ready directly so the port is low while rst is held, even
  // though the state register already reads IDLE.
  assign req_ready    = (state_q == IDLE) && init_calib_complete && !rst;

  // Write data path passes straight through; every beat is a full burst end.
  assign app_wdf_data = wr_data;
  assign app_wdf_wren = in_write && wr_valid && data_left;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;
  assign wr_ready     = in_write && app_wdf_rdy && data_left;

  // Commands only ever depend on state and monotonic counters, so once app_en
  // rises it stays up, with address and opcode unchanged, until accepted.
  assign app_en = (in_write && (cmd_cnt_q < data_cnt_q)) ||
                  ((state_q == READ) && (cmd_cnt_q < len_q) &&
                   (outstanding < LEN_WIDTH'(MAX_OUTSTANDING)));
  assign app_addr = addr_q;
  assign app_cmd  = cmd_q;

  assign req_fire  = req_valid && req_ready;
  assign cmd_fire  = app_en && app_rdy;
  assign beat_fire = app_wdf_wren && app_wdf_rdy;
  assign ret_fire  = in_read_phase && app_rd_data_valid;

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  // Transfer FSM with its burst counters and command address.
  // NOTE: state is assigned non-blocking only, so the counter updates and the
  // state decisions below all see the values from the start of the cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      addr_q     <= '0;
      cmd_q      <= CMD_WRITE;
      cmd_cnt_q  <= '0;
      data_cnt_q <= '0;
      rd_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= ret_fire;
      if (cmd_fire) begin
        cmd_cnt_q <= cmd_cnt_q + LEN_WIDTH'(1);
        addr_q    <= addr_q + ADDR_WIDTH'(ADDR_STEP);
      end
      if (beat_fire) data_cnt_q <= data_cnt_q + LEN_WIDTH'(1);
      if (ret_fire)  rd_cnt_q   <= rd_cnt_q + LEN_WIDTH'(1);

      unique case (state_q)
        IDLE: begin
          if (req_fire) begin
            len_q      <= req_len;
            addr_q     <= req_addr;
            cmd_q      <= req_wr ? CMD_WRITE : CMD_READ;
            cmd_cnt_q  <= '0;
            data_cnt_q <= '0;
            rd_cnt_q   <= '0;
            if (req_len == '0) state_q <= DONE;
            else if (req_wr)   state_q <= WRITE;
            else               state_q <= READ;
          end
        end
        WRITE: if ((data_cnt_q == len_q) && (cmd_cnt_q == len_q)) state_q <= DONE;
        READ:  if (cmd_cnt_q == len_q) state_q <= DRAIN;
        DRAIN: if (rd_cnt_q == len_q)  state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data capture register, one cycle behind the controller.
  // NOTE: the data word is qualified by rd_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    rd_data_q <= app_rd_data;
  end

endmodule
